// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with registered occupancy flags and overflow/underflow pulses.
// Build option: define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise DATA_OUT is registered with one-cycle read latency.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  FCLK,
  input  logic                  FRSTN,
  input  logic                  WR_EN,
  input  logic                  RD_EN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic                  rd_acc, wr_acc;

  // Acceptance decisions and next pointer/occupancy; a full FIFO may still take a write when a read frees a slot.
  always_comb begin
    rd_acc   = RD_EN && !empty_q;
    wr_acc   = WR_EN && (!full_q || rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d  = (wr_acc && !rd_acc) ? count_q + ONE_C :
               (rd_acc && !wr_acc) ? count_q - ONE_C : count_q;
  end

  // Storage is deliberately left unreset; only accepted writes touch it.
  always_ff @(posedge FCLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= DATA_IN;
  end

  // Pointers, count and flags; flags derive from next count so they always agree with COUNT.
  always_ff @(posedge FCLK or negedge FRSTN) begin
    if (!FRSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= count_d == DEPTH_C;
      empty_q  <= count_d == '0;
      af_q     <= count_d >= AF_C;
      ae_q     <= count_d <= AE_C;
      ovf_q    <= WR_EN && !wr_acc;
      udf_q    <= RD_EN && !rd_acc;
    end
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  assign DATA_OUT = empty_q ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  // Registered read port: the popped word appears the cycle after the accepted read and holds otherwise.
  always_ff @(posedge FCLK or negedge FRSTN) begin
    if (!FRSTN) dout_q <= '0;
    else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
  end

  assign DATA_OUT = dout_q;
`endif

  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed checks of fill, drain, wrap, simultaneous access and reset for param_sync_fifo.
module tb_param_sync_fifo;
  logic       FCLK = 1'b0;
  logic       FRSTN, WR_EN, RD_EN;
  logic [7:0] DATA_IN, DATA_OUT;
  logic       FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
  logic [4:0] COUNT;
  int         n_chk = 0;
  int         n_fail = 0;

  param_sync_fifo dut (
    .FCLK(FCLK), .FRSTN(FRSTN), .WR_EN(WR_EN), .RD_EN(RD_EN), .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT), .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL),
    .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 FCLK = ~FCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input int c);
    chk({tag, " count"}, 32'(COUNT), 32'(c));
    chk({tag, " empty"}, 32'(EMPTY), 32'(c == 0));
    chk({tag, " full"}, 32'(FULL), 32'(c == 16));
    chk({tag, " almost_full"}, 32'(ALMOST_FULL), 32'(c >= 14));
    chk({tag, " almost_empty"}, 32'(ALMOST_EMPTY), 32'(c <= 2));
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    WR_EN = w; RD_EN = r; DATA_IN = d;
    @(posedge FCLK);
    #1;
    WR_EN = 1'b0; RD_EN = 1'b0;
  endtask

  task automatic push(input string tag, input logic [7:0] d, input int c);
    step(1'b1, 1'b0, d);
    chk_occ(tag, c);
    chk({tag, " overflow"}, 32'(OVERFLOW), 32'd0);
  endtask

  task automatic pop(input string tag, input logic [7:0] d, input int c);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    chk({tag, " data"}, 32'(DATA_OUT), 32'(d));
    step(1'b0, 1'b1, 8'h00);
`else
    step(1'b0, 1'b1, 8'h00);
    chk({tag, " data"}, 32'(DATA_OUT), 32'(d));
`endif
    chk_occ(tag, c);
    chk({tag, " underflow"}, 32'(UNDERFLOW), 32'd0);
  endtask

  task automatic reset_outputs(input string tag);
    chk_occ(tag, 0);
    chk({tag, " data"}, 32'(DATA_OUT), 32'd0);
    chk({tag, " overflow"}, 32'(OVERFLOW), 32'd0);
    chk({tag, " underflow"}, 32'(UNDERFLOW), 32'd0);
  endtask

  initial begin
    FRSTN = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; DATA_IN = 8'h00;
    #10 FRSTN = 1'b0;
    #2 reset_outputs("reset_low");
    #8 FRSTN = 1'b1;
    #2 reset_outputs("reset_released");

    for (int i = 1; i <= 16; i++) push("fill", 8'(i), i);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    chk("fill data_out_held", 32'(DATA_OUT), 32'd0);
`endif
    step(1'b1, 1'b0, 8'h99);
    chk("overflow pulse", 32'(OVERFLOW), 32'd1);
    chk_occ("overflow", 16);
    step(1'b0, 1'b0, 8'h00);
    chk("overflow cleared", 32'(OVERFLOW), 32'd0);

    for (int i = 1; i <= 16; i++) pop("drain", 8'(i), 16 - i);
    step(1'b0, 1'b1, 8'h00);
    chk("underflow pulse", 32'(UNDERFLOW), 32'd1);
    chk_occ("underflow", 0);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    chk("underflow data_held", 32'(DATA_OUT), 32'h10);
`endif
    step(1'b0, 1'b0, 8'h00);
    chk("underflow cleared", 32'(UNDERFLOW), 32'd0);

    step(1'b1, 1'b1, 8'hA5);
    chk("simul_empty underflow", 32'(UNDERFLOW), 32'd1);
    chk_occ("simul_empty", 1);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    chk("fwft head visible", 32'(DATA_OUT), 32'hA5);
`else
    chk("std data before read", 32'(DATA_OUT), 32'h10);
`endif
    pop("read_a5", 8'hA5, 0);

    for (int i = 0; i < 16; i++) push("refill", 8'(8'h20 + i), i + 1);
    step(1'b1, 1'b1, 8'h30);
    chk("simul_full overflow", 32'(OVERFLOW), 32'd0);
    chk("simul_full underflow", 32'(UNDERFLOW), 32'd0);
    chk_occ("simul_full", 16);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    chk("simul_full data", 32'(DATA_OUT), 32'h20);
`endif
    for (int i = 1; i <= 16; i++) pop("drain2", 8'(8'h20 + i), 16 - i);

    for (int i = 0; i < 10; i++) push("wrap_w10", 8'(8'h40 + i), i + 1);
    for (int i = 0; i < 10; i++) pop("wrap_r10", 8'(8'h40 + i), 9 - i);
    for (int i = 0; i < 12; i++) push("wrap_w12", 8'(8'h60 + i), i + 1);
    for (int i = 0; i < 12; i++) pop("wrap_r12", 8'(8'h60 + i), 11 - i);

    for (int i = 0; i < 3; i++) push("pre_reset", 8'(8'hC0 + i), i + 1);
    #2 FRSTN = 1'b0;
    #1 reset_outputs("async_reset");
    #2 FRSTN = 1'b1;
    push("post_reset", 8'h77, 1);
    pop("post_reset_read", 8'h77, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
